// File: rtl/timebase_pkg.sv
// Shared constants for the timebase generator: channel limit, default width,
// and the reset-time divide/cascade defaults.
package timebase_pkg;

    localparam int unsigned NCH_MAX = 8;
    localparam int unsigned CW_DEF  = 16;

    // ch0 occupies the least significant CW_DEF bits
    localparam logic [3*CW_DEF-1:0] DIV_INIT_DEF = {16'd1000, 16'd1000, 16'd100};
    localparam logic [NCH_MAX-1:0]  CASCADE_DEF  = 8'b0000_0110;

endpackage

// File: rtl/timebase_gen_if.sv
// Control/status bundle of the timebase generator: enable, clear, divide
// write port, tick outputs and the stretched reset.
interface timebase_gen_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned CW  = timebase_pkg::CW_DEF
);

    logic           en;
    logic           clr;
    logic           div_wr;
    logic [2:0]     div_sel;
    logic [CW-1:0]  div_val;
    logic [NCH-1:0] tick;
    logic           rst_hold;
    logic           ready;

    modport master (
        output en, clr, div_wr, div_sel, div_val,
        input  tick, rst_hold, ready
    );

    modport slave (
        input  en, clr, div_wr, div_sel, div_val,
        output tick, rst_hold, ready
    );

endinterface

// File: rtl/timebase_ch.sv
// One tick channel: event counter, active/pending divide registers and a
// registered tick. A divide of 0 parks the channel with its counter at 0.
module timebase_ch #(
    parameter int unsigned    CW      = 16,
    parameter logic [CW-1:0]  DIV_RST = '0
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          i_evt,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_wr,
    input  logic [CW-1:0] i_val,
    output logic          o_tick
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_pend;
    logic          r_pend_vld;
    logic          r_tick;

    logic w_off;
    logic w_go;
    logic w_wrap;

    assign w_off  = (r_div == '0);
    assign w_go   = i_evt & i_en & ~w_off;
    assign w_wrap = w_go & (r_cnt == r_div - 1'b1);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_div      <= DIV_RST;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_off && i_wr) begin
            // A parked channel has no period to protect: take the value now.
            r_div      <= i_val;
            r_pend_vld <= 1'b0;
        end else begin
            // A write landing on the wrap cycle stays pending until the next wrap.
            if (w_wrap && r_pend_vld) begin
                r_div      <= r_pend;
                r_pend_vld <= 1'b0;
            end
            if (i_wr) begin
                r_pend     <= i_val;
                r_pend_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst || i_clr || w_off) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else if (w_go) begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/timebase_gen.sv
// Multi-channel tick generator with optional channel cascading and a
// post-reset hold stretcher; channels are replicated timebase_ch instances.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int unsigned          NCH      = 3,
    parameter int unsigned          CW       = CW_DEF,
    parameter int unsigned          RST_HOLD = 16,
    parameter logic [NCH*CW-1:0]    DIV_INIT = DIV_INIT_DEF,
    parameter logic [NCH_MAX-1:0]   CASCADE  = CASCADE_DEF
) (
    input  logic          clk_sys,
    input  logic          rst,
    timebase_gen_if.slave bus
);

    localparam int unsigned HW = $clog2(RST_HOLD + 1);

    logic [HW-1:0]  r_hcnt;
    logic           r_hold;
    logic           w_cnt_en;
    logic [NCH-1:0] w_tick;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_hcnt <= '0;
            r_hold <= 1'b1;
        end else if (r_hold) begin
            if (r_hcnt == HW'(RST_HOLD - 1)) begin
                r_hold <= 1'b0;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign w_cnt_en = bus.en & ~r_hold & ~bus.clr;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic w_evt;
        logic w_wr;

        // Cascaded channels count the registered tick of the channel below.
        if (k == 0 || !CASCADE[k]) begin : g_free
            assign w_evt = 1'b1;
        end else begin : g_casc
            assign w_evt = w_tick[k-1];
        end

        assign w_wr = bus.div_wr && (bus.div_sel == 3'(k));

        timebase_ch #(
            .CW      (CW),
            .DIV_RST (DIV_INIT[k*CW +: CW])
        ) u_ch (
            .clk_sys (clk_sys),
            .rst     (rst),
            .i_evt   (w_evt),
            .i_en    (w_cnt_en),
            .i_clr   (bus.clr),
            .i_wr    (w_wr),
            .i_val   (bus.div_val),
            .o_tick  (w_tick[k])
        );
    end

    assign bus.tick     = w_tick;
    assign bus.rst_hold = r_hold;
    assign bus.ready    = ~r_hold;

endmodule
